// File: rtl/lut_neuron_array_stream.sv
// lut_neuron_array_stream: array of runtime-loadable truth-table neurons on a
// valid/ready stream. Neuron k maps s_data slice k through its own table to
// m_data slice k. A config port rewrites table entries in place.
// Optional feature macro: LUT_READBACK_EN adds the cfg_re/cfg_rvalid/cfg_rdata
// table readback port.
module lut_neuron_array_stream #(
  parameter int N_NEURONS   = 4,
  parameter int IN_BITS     = 8,
  parameter int OUT_BITS    = 1,
  parameter int PIPE_STAGES = 1,
  localparam int SEL_W      = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [N_NEURONS*IN_BITS-1:0]  s_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [N_NEURONS*OUT_BITS-1:0] m_data,
  input  logic                          cfg_we,
  input  logic [SEL_W-1:0]              cfg_sel,
  input  logic [IN_BITS-1:0]            cfg_addr,
  input  logic [OUT_BITS-1:0]           cfg_wdata,
`ifdef LUT_READBACK_EN
  input  logic                          cfg_re,
  output logic                          cfg_rvalid,
  output logic [OUT_BITS-1:0]           cfg_rdata,
`endif
  output logic                          cfg_err
);

  localparam int DEPTH = 1 << IN_BITS;

  if (PIPE_STAGES != 1 && PIPE_STAGES != 2) begin : g_bad_pipe
    $error("lut_neuron_array_stream: PIPE_STAGES must be 1 or 2");
  end

  // Out-of-range select detection; impossible when SEL_W exactly covers N_NEURONS.
  logic sel_oob;
  if ((1 << SEL_W) > N_NEURONS) begin : g_oob
    assign sel_oob = (cfg_sel >= SEL_W'(N_NEURONS));
  end else begin : g_no_oob
    assign sel_oob = 1'b0;
  end

  logic [N_NEURONS*IN_BITS-1:0]  lk_in;
  logic                          lk_valid;
  logic [N_NEURONS*OUT_BITS-1:0] lk_data;
`ifdef LUT_READBACK_EN
  logic [OUT_BITS-1:0]           rd_word [N_NEURONS];
`endif

  for (genvar k = 0; k < N_NEURONS; k++) begin : g_neuron
    logic [OUT_BITS-1:0] tbl_q [DEPTH];

    // Table write port; deliberately outside rst so loaded models survive reset.
    always_ff @(posedge clk) begin
      if (cfg_we && cfg_sel == SEL_W'(k)) tbl_q[cfg_addr] <= cfg_wdata;
    end

    // Asynchronous read gives read-before-write against a same-cycle update.
    assign lk_data[k*OUT_BITS +: OUT_BITS] = tbl_q[lk_in[k*IN_BITS +: IN_BITS]];
`ifdef LUT_READBACK_EN
    assign rd_word[k] = tbl_q[cfg_addr];
`endif
  end

  logic                          m_valid_q, m_valid_d;
  logic [N_NEURONS*OUT_BITS-1:0] m_data_q, m_data_d;
  logic                          cfg_err_q, cfg_err_d;
  logic                          adv_out;

  assign adv_out = !m_valid_q || m_ready;

  if (PIPE_STAGES == 2) begin : g_in_reg
    logic                         v_in_q, v_in_d;
    logic [N_NEURONS*IN_BITS-1:0] d_in_q, d_in_d;
    logic                         adv_in;

    assign adv_in = !v_in_q || adv_out;

    // Input stage refills whenever it is empty or drains into the output stage.
    always_comb begin
      v_in_d = v_in_q;
      d_in_d = d_in_q;
      if (adv_in) begin
        v_in_d = s_valid;
        if (s_valid) d_in_d = s_data;
      end
    end

    // Input stage register.
    always_ff @(posedge clk) begin
      if (rst) begin
        v_in_q <= 1'b0;
        d_in_q <= '0;
      end else begin
        v_in_q <= v_in_d;
        d_in_q <= d_in_d;
      end
    end

    assign s_ready  = adv_in;
    assign lk_in    = d_in_q;
    assign lk_valid = v_in_q;
  end else begin : g_no_in_reg
    assign s_ready  = adv_out;
    assign lk_in    = s_data;
    assign lk_valid = s_valid;
  end

  // Output stage loads the table lookup whenever it can advance.
  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    if (adv_out) begin
      m_valid_d = lk_valid;
      if (lk_valid) m_data_d = lk_data;
    end
  end

`ifdef LUT_READBACK_EN
  logic                cfg_rvalid_q, cfg_rvalid_d;
  logic [OUT_BITS-1:0] cfg_rdata_q, cfg_rdata_d;
  logic [OUT_BITS-1:0] rd_sel;

  // Readback mux; a select matching no neuron returns zero.
  always_comb begin
    rd_sel = '0;
    for (int unsigned i = 0; i < N_NEURONS; i++) begin
      if (cfg_sel == SEL_W'(i)) rd_sel = rd_word[i];
    end
  end

  // Readback response: one-cycle valid pulse, data held until the next read.
  always_comb begin
    cfg_rvalid_d = cfg_re;
    cfg_rdata_d  = cfg_rdata_q;
    if (cfg_re) cfg_rdata_d = rd_sel;
  end

  // Readback response register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_rvalid_q <= 1'b0;
      cfg_rdata_q  <= '0;
    end else begin
      cfg_rvalid_q <= cfg_rvalid_d;
      cfg_rdata_q  <= cfg_rdata_d;
    end
  end

  assign cfg_rvalid = cfg_rvalid_q;
  assign cfg_rdata  = cfg_rdata_q;

  // Config error flags any out-of-range access, write or read.
  always_comb begin
    cfg_err_d = sel_oob && (cfg_we || cfg_re);
  end
`else
  // Config error flags an out-of-range write.
  always_comb begin
    cfg_err_d = sel_oob && cfg_we;
  end
`endif

  // Output stage and error pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_lut_neuron_array_stream.sv
// Testbench for lut_neuron_array_stream: randomized streams and table writes
// against a behavioural model (table arrays plus an in-flight beat queue).
// Five neurons are used so that an out-of-range cfg_sel is representable.
`timescale 1ns/1ps
module tb_lut_neuron_array_stream;
  localparam int NN    = 5;
  localparam int IB    = 8;
  localparam int OB    = 1;
  localparam int PS    = 1;
  localparam int SW    = (NN > 1) ? $clog2(NN) : 1;
  localparam int DEPTH = 1 << IB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic s_valid = 1'b0;
  logic m_ready = 1'b0;
  logic cfg_we = 1'b0;
  logic s_ready, m_valid, cfg_err;
  logic [NN*IB-1:0] s_data = '0;
  logic [NN*OB-1:0] m_data;
  logic [SW-1:0]    cfg_sel = '0;
  logic [IB-1:0]    cfg_addr = '0;
  logic [OB-1:0]    cfg_wdata = '0;
`ifdef LUT_READBACK_EN
  logic cfg_re = 1'b0;
  logic cfg_rvalid;
  logic [OB-1:0] cfg_rdata;
  logic exp_rvalid = 1'b0;
  logic [OB-1:0] exp_rdata = '0;
`endif

  // Reference model state
  logic [OB-1:0]    tmodel [NN][DEPTH];
  logic [NN*OB-1:0] out_q [$];
  logic [NN*OB-1:0] exp_mdata = '0;
  logic             exp_err = 1'b0;
  int n_tests = 0, n_fail = 0, cyc = 0, n_acc = 0, n_del = 0;

  lut_neuron_array_stream #(
    .N_NEURONS(NN), .IN_BITS(IB), .OUT_BITS(OB), .PIPE_STAGES(PS)
  ) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
`ifdef LUT_READBACK_EN
    .cfg_re(cfg_re), .cfg_rvalid(cfg_rvalid), .cfg_rdata(cfg_rdata),
`endif
    .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [NN*OB-1:0] model_lookup(input logic [NN*IB-1:0] d);
    logic [NN*OB-1:0] r;
    r = '0;
    for (int k = 0; k < NN; k++) r[k*OB +: OB] = tmodel[k][d[k*IB +: IB]];
    return r;
  endfunction

  function automatic logic [NN*IB-1:0] rand_data();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[NN*IB-1:0];
  endfunction

  // One clock: check outputs at the falling edge, advance the model at the
  // rising edge, return 1ns after it so callers can drive the next inputs.
  task automatic cycle();
    bit exp_sready, acc, pop;
    @(negedge clk);
    exp_sready = (out_q.size() == 0) || m_ready;
    check_eq("s_ready", s_ready, exp_sready);
    check_eq("m_valid", m_valid, out_q.size() != 0);
    check_eq("m_data", m_data, exp_mdata);
    check_eq("cfg_err", cfg_err, exp_err);
`ifdef LUT_READBACK_EN
    check_eq("cfg_rvalid", cfg_rvalid, exp_rvalid);
    if (exp_rvalid) check_eq("cfg_rdata", cfg_rdata, exp_rdata);
`endif
    acc = s_valid && exp_sready;
    pop = (out_q.size() != 0) && m_ready;
    @(posedge clk);
    cyc++;
    if (rst) begin
      out_q.delete();
      exp_mdata = '0;
      exp_err   = 1'b0;
`ifdef LUT_READBACK_EN
      exp_rvalid = 1'b0;
      exp_rdata  = '0;
`endif
    end else begin
      if (pop) begin
        void'(out_q.pop_front());
        n_del++;
      end
      if (acc) begin
        exp_mdata = model_lookup(s_data);
        out_q.push_back(exp_mdata);
        n_acc++;
      end
      exp_err = cfg_we && (cfg_sel >= NN);
`ifdef LUT_READBACK_EN
      exp_err = (cfg_we || cfg_re) && (cfg_sel >= NN);
      exp_rvalid = cfg_re;
      if (cfg_re) begin
        if (cfg_sel < NN) exp_rdata = tmodel[cfg_sel][cfg_addr];
        else exp_rdata = '0;
      end
`endif
    end
    // Tables are never touched by reset.
    if (cfg_we && cfg_sel < NN) tmodel[cfg_sel][cfg_addr] = cfg_wdata;
    #1;
  endtask

  task automatic idle();
    s_valid = 1'b0;
    cfg_we  = 1'b0;
`ifdef LUT_READBACK_EN
    cfg_re  = 1'b0;
`endif
  endtask

  task automatic drain();
    int g;
    g = 0;
    m_ready = 1'b1;
    while (out_q.size() != 0 && g < 8) begin
      cycle();
      g++;
    end
    check_eq("drain_empty", out_q.size(), 0);
  endtask

  task automatic wr(input int sel, input int addr, input logic [OB-1:0] d);
    cfg_we    = 1'b1;
    cfg_sel   = SW'(sel);
    cfg_addr  = IB'(addr);
    cfg_wdata = d;
    cycle();
    cfg_we    = 1'b0;
  endtask

  task automatic stream(input int n, input int vpct, input int rpct, input bit cfg_noise);
    int target, guard;
    target = n_acc + n;
    guard  = 0;
    while (n_acc < target && guard < 40*n + 100) begin
      s_valid   = (int'($urandom_range(0, 99)) < vpct);
      s_data    = rand_data();
      m_ready   = (int'($urandom_range(0, 99)) < rpct);
      cfg_we    = cfg_noise && ($urandom_range(0, 7) == 0);
      cfg_sel   = SW'($urandom_range(0, NN-1));
      cfg_addr  = IB'($urandom);
      cfg_wdata = OB'($urandom);
`ifdef LUT_READBACK_EN
      cfg_re    = cfg_noise && ($urandom_range(0, 7) == 0);
`endif
      cycle();
      guard++;
    end
    check_eq("stream_accepted", n_acc >= target, 1'b1);
    idle();
    drain();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int start, base_acc, base_del, g;
    bit pat [4];
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_eq("rst_m_valid", m_valid, 1'b0);
    check_eq("rst_m_data", m_data, '0);
    check_eq("rst_s_ready", s_ready, 1'b1);
    check_eq("rst_cfg_err", cfg_err, 1'b0);
`ifdef LUT_READBACK_EN
    check_eq("rst_cfg_rvalid", cfg_rvalid, 1'b0);
    check_eq("rst_cfg_rdata", cfg_rdata, '0);
`endif

    // 1: neuron0 T[a] = a[0]|a[7], others 0; full-rate sweep of all addresses
    for (int k = 0; k < NN; k++)
      for (int a = 0; a < DEPTH; a++)
        wr(k, a, (k == 0) ? OB'((a & 1) | ((a >> 7) & 1)) : '0);
    m_ready  = 1'b1;
    start    = cyc;
    base_del = n_del;
    for (int a = 0; a < DEPTH; a++) begin
      s_valid = 1'b1;
      s_data  = rand_data();
      s_data[IB-1:0] = IB'(a);
      cycle();
      if (a == 0) check_eq("t1_first_valid", m_valid, 1'b1);
      check_eq("t1_n0", m_data[0], (a & 1) | ((a >> 7) & 1));
      check_eq("t1_others", m_data[NN*OB-1:OB], '0);
    end
    idle();
    g = 0;
    while (n_del - base_del < DEPTH && g < 8) begin
      cycle();
      g++;
    end
    check_eq("t1_delivered", n_del - base_del, DEPTH);
    check_eq("t1_cycles", cyc - start, DEPTH + PS);

    // 2: 16 beats with m_ready pattern 1,0,0,1
    base_acc = n_acc;
    base_del = n_del;
    g = 0;
    while (n_acc - base_acc < 16 && g < 200) begin
      s_valid = 1'b1;
      s_data  = rand_data();
      m_ready = pat[g % 4];
      cycle();
      g++;
    end
    idle();
    drain();
    check_eq("t2_accepted", n_acc - base_acc, 16);
    check_eq("t2_delivered", n_del - base_del, 16);

    // 3: write T0[0x80]=0 in the cycle a 0x80 beat is accepted
    m_ready   = 1'b1;
    s_valid   = 1'b1;
    s_data    = rand_data();
    s_data[IB-1:0] = 8'h80;
    cfg_we    = 1'b1;
    cfg_sel   = '0;
    cfg_addr  = 8'h80;
    cfg_wdata = '0;
    cycle();
    cfg_we = 1'b0;
    check_eq("t3_old_value", m_data[0], 1'b1);
    s_data = rand_data();
    s_data[IB-1:0] = 8'h80;
    cycle();
    check_eq("t3_new_value", m_data[0], 1'b0);
    idle();
    drain();

    // 4: out-of-range writes pulse cfg_err for one cycle, no table change
    wr(NN, int'($urandom_range(0, DEPTH-1)), 1'b1);
    check_eq("t4_err_pulse", cfg_err, 1'b1);
    cycle();
    check_eq("t4_err_clear", cfg_err, 1'b0);
    wr((1 << SW) - 1, 8'h80, 1'b1);
    check_eq("t4_err_pulse_max", cfg_err, 1'b1);
    stream(64, 100, 100, 1'b0);

    // 5: random tables on the other neurons, then reset with beats in flight
    for (int k = 1; k < NN; k++)
      for (int a = 0; a < DEPTH; a++)
        wr(k, a, OB'($urandom));
    m_ready = 1'b0;
    s_valid = 1'b1;
    s_data  = rand_data();
    cycle();
    check_eq("t5_full_s_ready", s_ready, 1'b0);
    s_data = rand_data();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check_eq("t5_m_valid", m_valid, 1'b0);
    check_eq("t5_s_ready", s_ready, 1'b1);
    idle();
    stream(64, 80, 70, 1'b0);

`ifdef LUT_READBACK_EN
    // 6: readback
    wr(2, 8'h3C, 1'b1);
    cfg_re   = 1'b1;
    cfg_sel  = SW'(2);
    cfg_addr = 8'h3C;
    cycle();
    cfg_re = 1'b0;
    check_eq("t6_rvalid", cfg_rvalid, 1'b1);
    check_eq("t6_rdata", cfg_rdata, 1'b1);
    cfg_re = 1'b1;
    cfg_we = 1'b1;
    cfg_wdata = '0;
    cycle();
    cfg_we = 1'b0;
    check_eq("t6_rdw_old", cfg_rdata, 1'b1);
    cycle();
    check_eq("t6_after_write", cfg_rdata, 1'b0);
    cfg_sel = SW'(NN);
    cycle();
    cfg_re = 1'b0;
    check_eq("t6_oob_rvalid", cfg_rvalid, 1'b1);
    check_eq("t6_oob_rdata", cfg_rdata, '0);
    check_eq("t6_oob_err", cfg_err, 1'b1);
    cycle();
    check_eq("t6_rvalid_pulse", cfg_rvalid, 1'b0);
`endif

    // Randomized streams with table writes mixed in
    stream(300, 75, 65, 1'b1);
    stream(200, 100, 100, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
